assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache between the CPU pipeline (instruction or data port) and the shared 128-bit memory interface. It generalises the direct-mapped cache with configurable ways and sets, pseudo-LRU replacement, and flop-held valid/dirty state. That state clears on reset, so no SRAM initialisation pass is needed. Tags and data live in single-port SRAM macros; each line is 512 bits, transferred as 4 memory beats.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/plru_update.sv | 34 +++
 rtl/assoc_cache.sv | 242 ++++++++++++++++++++++++
 tb/tb_assoc_cache.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the set-associative cache.
// Line = 16 CPU words = 4 beats of 128 bits.
package cache_pkg;

   localparam int OFFSET_BITS = 4;
   localparam int BEATS       = 4;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_WB_REQ    = 3'd2,
      S_WB_DATA   = 3'd3,
      S_FILL_REQ  = 3'd4,
      S_FILL_DATA = 3'd5,
      S_REPLAY    = 3'd6
   } state_e;

   function automatic int idx_bits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_bits(input int word_addr_bits, input int sets);
      return word_addr_bits - idx_bits(sets) - OFFSET_BITS;
   endfunction

   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   function automatic int plru_bits(input int ways);
      return (ways > 1) ? ways - 1 : 1;
   endfunction

endpackage

// File: rtl/plru_update.sv
// Pseudo-LRU victim selection and next-state after an access, for 1, 2 or 4 ways.
// Each tree bit points toward the side that should be evicted next.
module plru_update
   import cache_pkg::*;
#(
   parameter int WAYS = 2
) (
   input  logic [plru_bits(WAYS)-1:0] plru_i,
   input  logic [way_bits(WAYS)-1:0]  access_way_i,
   output logic [way_bits(WAYS)-1:0]  victim_o,
   output logic [plru_bits(WAYS)-1:0] plru_o
);

   if (WAYS == 4) begin : g_four
      always_comb begin
         victim_o = plru_i[0] ? {1'b1, plru_i[2]} : {1'b0, plru_i[1]};
         plru_o    = plru_i;
         plru_o[0] = ~access_way_i[1];
         if (!access_way_i[1]) plru_o[1] = ~access_way_i[0];
         else                  plru_o[2] = ~access_way_i[0];
      end
   end else if (WAYS == 2) begin : g_two
      always_comb begin
         victim_o = plru_i;
         plru_o   = ~access_way_i;
      end
   end else begin : g_one
      always_comb begin
         victim_o = '0;
         plru_o   = plru_i;
      end
   end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back, write-allocate cache with PLRU replacement.
// Valid/dirty/PLRU live in flops; tags and data are single-port SRAMs with registered reads.
module assoc_cache #(
   parameter int WAYS           = 2,
   parameter int SETS           = 64,
   parameter int CPU_WIDTH      = 32,
   parameter int WORD_ADDR_BITS = 30,
   parameter int BEATS          = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cpu_req_valid,
   output logic                      cpu_req_ready,
   input  logic [WORD_ADDR_BITS-1:0] cpu_req_addr,
   input  logic [CPU_WIDTH-1:0]      cpu_req_data,
   input  logic [3:0]                cpu_req_write,
   output logic                      cpu_resp_valid,
   output logic [CPU_WIDTH-1:0]      cpu_resp_data,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [WORD_ADDR_BITS-3:0] mem_req_addr,
   output logic                      mem_req_rw,
   output logic                      mem_req_data_valid,
   input  logic                      mem_req_data_ready,
   output logic [127:0]              mem_req_data_bits,
   output logic [15:0]               mem_req_data_mask,
   input  logic                      mem_resp_valid,
   input  logic [127:0]              mem_resp_data,
   output logic [2:0]                dbg_state
);
   import cache_pkg::*;

   localparam int IDX_BITS  = idx_bits(SETS);
   localparam int TAG_BITS  = tag_bits(WORD_ADDR_BITS, SETS);
   localparam int WAY_BITS  = way_bits(WAYS);
   localparam int PLRU_BITS = plru_bits(WAYS);

   state_e                         state_q, state_d;
   logic [WORD_ADDR_BITS-1:0]      addr_q, addr_d;
   logic [CPU_WIDTH-1:0]           wdata_q, wdata_d;
   logic [3:0]                     wmask_q, wmask_d;
   logic [WAY_BITS-1:0]            victim_q, victim_d;
   logic [1:0]                     cnt_q, cnt_d;
   logic                           init_q, init_d;
   logic [SETS-1:0][WAYS-1:0]      valid_q, valid_d;
   logic [SETS-1:0][WAYS-1:0]      dirty_q, dirty_d;
   logic [SETS-1:0][PLRU_BITS-1:0] plru_q, plru_d;

   logic [TAG_BITS-1:0] tag_mem [WAYS][SETS];
   logic [127:0]        data_mem [WAYS][BEATS][SETS];
   logic [TAG_BITS-1:0] tag_rd_q [WAYS];
   logic [TAG_BITS-1:0] tag_rd_d [WAYS];
   logic [127:0]        data_rd_q [WAYS][BEATS];
   logic [127:0]        data_rd_d [WAYS][BEATS];

   logic [IDX_BITS-1:0] idx, rd_idx;
   logic [TAG_BITS-1:0] tag;
   logic [1:0]          bank, word;
   logic                accept, rd_en, is_store, fill_last;
   logic [WAYS-1:0]     hit_vec;
   logic                hit, any_inv;
   logic [WAY_BITS-1:0] hit_way, inv_way, plru_victim, victim_sel;
   logic [PLRU_BITS-1:0] plru_next;
   logic [127:0]        beat_rd, merged;
   logic                tag_we, data_we;
   logic [WAY_BITS-1:0] data_way;
   logic [1:0]          data_bank;
   logic [127:0]        data_wdata;

   assign idx      = addr_q[OFFSET_BITS +: IDX_BITS];
   assign tag      = addr_q[WORD_ADDR_BITS-1 -: TAG_BITS];
   assign bank     = addr_q[3:2];
   assign word     = addr_q[1:0];
   assign is_store = |wmask_q;

   // Ready is held off until the first clock after reset releases.
   assign cpu_req_ready = (state_q == S_IDLE) && init_q;
   assign accept        = cpu_req_valid && cpu_req_ready;
   assign rd_en         = accept || (state_q == S_REPLAY);
   assign rd_idx        = accept ? cpu_req_addr[OFFSET_BITS +: IDX_BITS] : idx;
   assign fill_last     = (state_q == S_FILL_DATA) && mem_resp_valid && (cnt_q == 2'(BEATS - 1));

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      inv_way = '0;
      any_inv = 1'b0;
      for (int w = 0; w < WAYS; w++)
         hit_vec[w] = valid_q[idx][w] && (tag_rd_q[w] == tag);
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = WAY_BITS'(w);
         if (!valid_q[idx][w]) begin
            inv_way = WAY_BITS'(w);
            any_inv = 1'b1;
         end
      end
   end

   assign hit        = |hit_vec;
   assign victim_sel = any_inv ? inv_way : plru_victim;

   plru_update #(.WAYS(WAYS)) u_plru (
      .plru_i       (plru_q[idx]),
      .access_way_i (hit_way),
      .victim_o     (plru_victim),
      .plru_o       (plru_next)
   );

   assign beat_rd        = data_rd_q[hit_way][bank];
   assign cpu_resp_data  = beat_rd[CPU_WIDTH*word +: CPU_WIDTH];
   assign cpu_resp_valid = (state_q == S_LOOKUP) && hit && !is_store;

   always_comb begin
      merged = beat_rd;
      for (int k = 0; k < 16; k++)
         if (((k / 4) == int'(word)) && wmask_q[k % 4])
            merged[8*k +: 8] = wdata_q[8*(k % 4) +: 8];
   end

   assign mem_req_valid      = (state_q == S_WB_REQ) || (state_q == S_FILL_REQ);
   assign mem_req_rw         = (state_q == S_WB_REQ);
   assign mem_req_addr       = (state_q == S_WB_REQ) ? {tag_rd_q[victim_q], idx, 2'b00}
                                                     : {tag, idx, 2'b00};
   assign mem_req_data_valid = (state_q == S_WB_DATA);
   assign mem_req_data_bits  = data_rd_q[victim_q][cnt_q];
   assign mem_req_data_mask  = '1;
   assign dbg_state          = state_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      victim_d = victim_q;
      cnt_d    = cnt_q;
      init_d   = 1'b1;
      valid_d  = valid_q;
      dirty_d  = dirty_q;
      plru_d   = plru_q;
      case (state_q)
         S_IDLE: if (accept) begin
            addr_d  = cpu_req_addr;
            wdata_d = cpu_req_data;
            wmask_d = cpu_req_write;
            state_d = S_LOOKUP;
         end
         S_LOOKUP: if (hit) begin
            if (is_store) dirty_d[idx][hit_way] = 1'b1;
            plru_d[idx] = plru_next;
            state_d     = S_IDLE;
         end else begin
            victim_d = victim_sel;
            state_d  = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) ? S_WB_REQ : S_FILL_REQ;
         end
         S_WB_REQ: if (mem_req_ready) begin
            cnt_d   = '0;
            state_d = S_WB_DATA;
         end
         S_WB_DATA: if (mem_req_data_ready) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'(BEATS - 1)) state_d = S_FILL_REQ;
         end
         S_FILL_REQ: if (mem_req_ready) begin
            cnt_d   = '0;
            state_d = S_FILL_DATA;
         end
         S_FILL_DATA: if (mem_resp_valid) begin
            cnt_d = cnt_q + 2'd1;
            if (fill_last) begin
               valid_d[idx][victim_q] = 1'b1;
               dirty_d[idx][victim_q] = 1'b0;
               state_d = S_REPLAY;
            end
         end
         S_REPLAY: state_d = S_LOOKUP;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wmask_q  <= '0;
         victim_q <= '0;
         cnt_q    <= '0;
         init_q   <= 1'b0;
         valid_q  <= '0;
         dirty_q  <= '0;
         plru_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
         victim_q <= victim_d;
         cnt_q    <= cnt_d;
         init_q   <= init_d;
         valid_q  <= valid_d;
         dirty_q  <= dirty_d;
         plru_q   <= plru_d;
      end
   end

   // Reads (IDLE accept, REPLAY) and writes (LOOKUP store, FILL_DATA) never share a cycle.
   always_comb begin
      tag_we     = fill_last;
      data_we    = 1'b0;
      data_way   = victim_q;
      data_bank  = cnt_q;
      data_wdata = mem_resp_data;
      if ((state_q == S_FILL_DATA) && mem_resp_valid) begin
         data_we = 1'b1;
      end else if ((state_q == S_LOOKUP) && hit && is_store) begin
         data_we    = 1'b1;
         data_way   = hit_way;
         data_bank  = bank;
         data_wdata = merged;
      end
   end

   always_comb begin
      tag_rd_d  = tag_rd_q;
      data_rd_d = data_rd_q;
      if (rd_en) begin
         for (int w = 0; w < WAYS; w++) begin
            tag_rd_d[w] = tag_mem[w][rd_idx];
            for (int b = 0; b < BEATS; b++)
               data_rd_d[w][b] = data_mem[w][b][rd_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      tag_rd_q  <= tag_rd_d;
      data_rd_q <= data_rd_d;
      if (tag_we)  tag_mem[victim_q][idx] <= tag;
      if (data_we) data_mem[data_way][data_bank][idx] <= data_wdata;
   end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (2 ways, 64 sets): misses, hits, stores,
// dirty eviction with back-pressure, and reset in the middle of a fill.
module tb_assoc_cache;

   logic         clk = 1'b0;
   logic         reset;
   logic         cpu_req_valid;
   logic         cpu_req_ready;
   logic [29:0]  cpu_req_addr;
   logic [31:0]  cpu_req_data;
   logic [3:0]   cpu_req_write;
   logic         cpu_resp_valid;
   logic [31:0]  cpu_resp_data;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic [27:0]  mem_req_addr;
   logic         mem_req_rw;
   logic         mem_req_data_valid;
   logic         mem_req_data_ready;
   logic [127:0] mem_req_data_bits;
   logic [15:0]  mem_req_data_mask;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_data;
   logic [2:0]   dbg_state;

   int checks = 0;
   int errors = 0;

   assoc_cache #(.WAYS(2), .SETS(64), .CPU_WIDTH(32), .WORD_ADDR_BITS(30), .BEATS(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .cpu_req_valid      (cpu_req_valid),
      .cpu_req_ready      (cpu_req_ready),
      .cpu_req_addr       (cpu_req_addr),
      .cpu_req_data       (cpu_req_data),
      .cpu_req_write      (cpu_req_write),
      .cpu_resp_valid     (cpu_resp_valid),
      .cpu_resp_data      (cpu_resp_data),
      .mem_req_valid      (mem_req_valid),
      .mem_req_ready      (mem_req_ready),
      .mem_req_addr       (mem_req_addr),
      .mem_req_rw         (mem_req_rw),
      .mem_req_data_valid (mem_req_data_valid),
      .mem_req_data_ready (mem_req_data_ready),
      .mem_req_data_bits  (mem_req_data_bits),
      .mem_req_data_mask  (mem_req_data_mask),
      .mem_resp_valid     (mem_resp_valid),
      .mem_resp_data      (mem_resp_data),
      .dbg_state          (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_req(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
      int n = 0;
      cpu_req_valid = 1'b1;
      cpu_req_addr  = a;
      cpu_req_data  = d;
      cpu_req_write = m;
      while (cpu_req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("req_ready", cpu_req_ready, 1'b1);
      tick();
      cpu_req_valid = 1'b0;
      cpu_req_write = 4'b0000;
   endtask

   task automatic wait_cmd(input string tag, input logic [27:0] exp_addr, input logic exp_rw, input int stall);
      int n = 0;
      while (mem_req_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, mem_req_valid, 1'b1);
      check({tag, "_addr"}, mem_req_addr, exp_addr);
      check({tag, "_rw"}, mem_req_rw, exp_rw);
      for (int i = 0; i < stall; i++) begin
         tick();
         check({tag, "_hold_valid"}, mem_req_valid, 1'b1);
         check({tag, "_hold_addr"}, mem_req_addr, exp_addr);
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
   endtask

   task automatic send_fill(input logic [127:0] b0, input logic [31:0] base);
      for (int k = 0; k < 4; k++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = (k == 0) ? b0 : {4{base + 32'(k)}};
         tick();
      end
      mem_resp_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input logic [31:0] exp);
      int n = 0;
      while (cpu_resp_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_resp_valid"}, cpu_resp_valid, 1'b1);
      check({tag, "_resp_data"}, cpu_resp_data, exp);
   endtask

   logic [127:0] line_a_b0;
   logic [127:0] wb_b0;

   initial begin
      line_a_b0 = {32'h0000_0003, 32'h0000_0002, 32'h1111_1111, 32'hDEAD_BEEF};
      wb_b0     = {32'h0000_0003, 32'h0000_0002, 32'h1111_1111, 32'hDEAD_CAFE};
      reset = 1'b1;
      cpu_req_valid = 1'b0;
      cpu_req_addr = '0;
      cpu_req_data = '0;
      cpu_req_write = '0;
      mem_req_ready = 1'b0;
      mem_req_data_ready = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data = '0;

      // Reset state
      tick();
      check("rst_ready", cpu_req_ready, 1'b0);
      check("rst_resp_valid", cpu_resp_valid, 1'b0);
      check("rst_mem_valid", mem_req_valid, 1'b0);
      check("rst_data_valid", mem_req_data_valid, 1'b0);
      check("rst_state", dbg_state, 3'd0);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_ready", cpu_req_ready, 1'b1);
      check("wmask_ones", mem_req_data_mask, 16'hFFFF);

      // Cold miss on 0x100 -> fill from beat address 0x40
      cpu_req(30'h100, 32'h0, 4'b0000);
      check("miss_no_resp", cpu_resp_valid, 1'b0);
      wait_cmd("fill_a", 28'h40, 1'b0, 0);
      send_fill(line_a_b0, 32'hA000_0000);
      wait_resp("load_100", 32'hDEAD_BEEF);

      // Hit on the same line: response one cycle after accept, no memory traffic
      cpu_req(30'h101, 32'h0, 4'b0000);
      check("hit_resp_valid", cpu_resp_valid, 1'b1);
      check("hit_resp_data", cpu_resp_data, 32'h1111_1111);
      check("hit_no_mem", mem_req_valid, 1'b0);
      tick();
      check("hit_next_ready", cpu_req_ready, 1'b1);
      cpu_req(30'h10F, 32'h0, 4'b0000);
      check("hit_last_word", cpu_resp_data, 32'hA000_0003);
      check("hit_last_valid", cpu_resp_valid, 1'b1);

      // Byte-masked store, then reload
      cpu_req(30'h100, 32'h0000_CAFE, 4'b0011);
      check("store_no_resp", cpu_resp_valid, 1'b0);
      check("store_no_mem", mem_req_valid, 1'b0);
      cpu_req(30'h100, 32'h0, 4'b0000);
      check("store_merge", cpu_resp_data, 32'hDEAD_CAFE);
      check("store_merge_valid", cpu_resp_valid, 1'b1);

      // Second line in the same set fills the other (invalid) way
      cpu_req(30'h500, 32'h0, 4'b0000);
      wait_cmd("fill_b", 28'h140, 1'b0, 0);
      send_fill({4{32'h5000_0000}}, 32'h5000_0000);
      wait_resp("load_500", 32'h5000_0000);

      // Third line evicts the dirty 0x100 line, with back-pressure on both channels
      cpu_req(30'h900, 32'h0, 4'b0000);
      wait_cmd("wb", 28'h40, 1'b1, 5);
      mem_req_data_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("wb_stall_valid", mem_req_data_valid, 1'b1);
         check("wb_stall_bits", mem_req_data_bits, wb_b0);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         mem_req_data_ready = 1'b1;
         check("wb_beat_valid", mem_req_data_valid, 1'b1);
         check("wb_beat_bits", mem_req_data_bits, (k == 0) ? wb_b0 : {4{32'hA000_0000 + 32'(k)}});
         tick();
      end
      mem_req_data_ready = 1'b0;
      check("wb_done", mem_req_data_valid, 1'b0);
      wait_cmd("fill_c", 28'h240, 1'b0, 0);
      send_fill({4{32'h9000_0000}}, 32'h9000_0000);
      wait_resp("load_900", 32'h9000_0000);

      // 0x100 misses again (clean victim 0x500); reset lands on beat 2 of the fill
      cpu_req(30'h100, 32'h0, 4'b0000);
      wait_cmd("fill_d", 28'h40, 1'b0, 0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = line_a_b0;
      tick();
      mem_resp_data  = {4{32'hA000_0001}};
      tick();
      mem_resp_data  = {4{32'hA000_0002}};
      reset = 1'b1;
      #1;
      check("midrst_ready", cpu_req_ready, 1'b0);
      check("midrst_mem_valid", mem_req_valid, 1'b0);
      check("midrst_data_valid", mem_req_data_valid, 1'b0);
      check("midrst_resp_valid", cpu_resp_valid, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      mem_resp_valid = 1'b0;
      check("midrst_ready_low", cpu_req_ready, 1'b0);
      tick();
      check("midrst_ready_high", cpu_req_ready, 1'b1);

      // Everything was invalidated, so the same address misses and refills
      cpu_req(30'h100, 32'h0, 4'b0000);
      check("after_rst_miss", cpu_resp_valid, 1'b0);
      wait_cmd("fill_e", 28'h40, 1'b0, 0);
      send_fill({4{32'h7777_0000}}, 32'h7777_0000);
      wait_resp("load_after_rst", 32'h7777_0000);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
